bin2bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) converter from an unsigned binary value to 8 packed BCD digits.
- Sits directly upstream of the 8-digit multiplexed seven-segment driver.
  - Its bcd output feeds the driver's 32-bit num input; digit 0 is in bits [3:0].
  - Its display_en output feeds the driver's display enable.
- Converts one value per request using a start/busy/done handshake, and holds the last result stable between conversions.

---
 rtl/bin2bcd_seq_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between the binary-to-BCD converter and its client.
// The master side issues start/bin and consumes the BCD result and status flags.
interface bin2bcd_seq_if #(
  parameter int unsigned IN_W = 27
);
  logic            start;
  logic [IN_W-1:0] bin;
  logic            busy;
  logic            done;
  logic [31:0]     bcd;
  logic            overflow;
  logic            display_en;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow, display_en
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow, display_en
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: IN_W-bit unsigned binary to 8 packed BCD digits,
// one bit per clock, with start/busy/done handshake and saturation above MAX_VAL.
module bin2bcd_seq #(
  parameter int unsigned IN_W    = 27,
  parameter int unsigned MAX_VAL = 99999999
) (
  input logic          clk,
  input logic          rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(IN_W + 1);

  if (IN_W == 0 || IN_W > 27) begin : g_bad_in_w
    $error("bin2bcd_seq: IN_W must be in 1..27");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD
  } state_t;

  state_t          state;
  logic [IN_W-1:0] binreg;
  logic [31:0]     scratch;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nx;
  logic [30:0]     adj;
  logic            bin_over;
  logic            busy;
  logic            done;
  logic [31:0]     bcd;
  logic            overflow;
  logic            display_en;

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.bcd        = bcd;
  assign bus.overflow   = overflow;
  assign bus.display_en = display_en;

  // Zero-extended compare; for IN_W < 27 the input cannot reach MAX_VAL and this folds to 0.
  assign bin_over = 32'(bus.bin) > MAX_VAL;
  assign count_nx = count + CW'(1);

  // Top digit only needs its low 3 bits after adjust: its MSB is shifted out anyway.
  always_comb begin
    adj = scratch[30:0];
    for (int unsigned i = 0; i < 7; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
    end
    if (scratch[31:28] >= 4'd5) begin
      adj[30:28] = scratch[30:28] + 3'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      binreg     <= '0;
      scratch    <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
      display_en <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            binreg   <= bus.bin;
            scratch  <= '0;
            count    <= '0;
            busy     <= 1'b1;
            overflow <= bin_over;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= {adj, binreg[IN_W-1]};
          binreg  <= binreg << 1;
          count   <= count_nx;
          if (count_nx == CW'(IN_W)) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          bcd        <= overflow ? 32'h9999_9999 : scratch;
          done       <= 1'b1;
          busy       <= 1'b0;
          display_en <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic scratch_bcd_ok;

  always_comb begin
    scratch_bcd_ok = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (scratch[i*4 +: 4] > 4'd9) begin
        scratch_bcd_ok = 1'b0;
      end
    end
  end

  a_scratch_bcd : assert property (@(posedge clk) disable iff (!rst_n) scratch_bcd_ok);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized check of bin2bcd_seq against an arithmetic divide-by-ten model.
module tb_bin2bcd_seq;

  localparam int unsigned IN_W    = 27;
  localparam int unsigned MAX_VAL = 99999999;
  localparam int unsigned LAT     = IN_W + 1;
  localparam int unsigned PERIOD  = IN_W + 2;
  localparam int unsigned NCONT   = 3 * PERIOD;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [31:0] last_bcd;

  bin2bcd_seq_if #(.IN_W(IN_W)) bif ();

  bin2bcd_seq #(
    .IN_W   (IN_W),
    .MAX_VAL(MAX_VAL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] bcd_ref(input logic [26:0] v);
    int unsigned x;
    logic [31:0] r;
    x = 32'(v);
    r = '0;
    if (x > MAX_VAL) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [26:0] val);
    logic [31:0] exp;
    int n;
    int busy_n;
    exp = bcd_ref(val);
    bif.start = 1'b1;
    bif.bin   = val;
    step();
    bif.start = 1'b0;
    check_bit("ovf_at_accept", bif.overflow, 32'(val) > MAX_VAL);
    check_word("bcd_held_busy", bif.bcd, last_bcd);
    n      = 0;
    busy_n = bif.busy ? 1 : 0;
    while (!bif.done && n < 40) begin
      bif.bin = 27'($urandom);
      step();
      n++;
      if (bif.busy) busy_n++;
    end
    check_int("latency", n, LAT);
    check_int("busy_cycles", busy_n, LAT);
    check_word("bcd", bif.bcd, exp);
    check_bit("overflow_at_done", bif.overflow, 32'(val) > MAX_VAL);
    check_bit("display_en", bif.display_en, 1'b1);
    check_bit("busy_at_done", bif.busy, 1'b0);
    step();
    check_bit("done_one_cycle", bif.done, 1'b0);
    check_word("bcd_held_idle", bif.bcd, exp);
    last_bcd = exp;
  endtask

  initial begin
    logic [26:0] b [NCONT];
    int j;
    vectors     = 0;
    miscompares = 0;
    last_bcd    = '0;
    rst_n       = 1'b0;
    bif.start   = 1'b0;
    bif.bin     = '0;

    #2;
    check_word("rst_bcd", bif.bcd, 32'h0);
    check_bit("rst_busy", bif.busy, 1'b0);
    check_bit("rst_done", bif.done, 1'b0);
    check_bit("rst_overflow", bif.overflow, 1'b0);
    check_bit("rst_display_en", bif.display_en, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_bit("idle_display_en", bif.display_en, 1'b0);

    convert(27'd0);
    convert(27'd12345678);
    convert(27'd99999999);
    convert(27'd255);
    convert(27'd100000000);
    convert(27'd42);
    convert(27'h7ff_ffff);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) convert(27'($urandom_range(MAX_VAL, 0)));
      else            convert(27'($urandom));
    end

    // start held high, bin changing every edge: acceptance only every PERIOD edges
    for (int i = 0; i < int'(NCONT); i++) b[i] = 27'($urandom);
    for (int i = 0; i < int'(NCONT); i += 4) b[i] = 27'($urandom_range(MAX_VAL, 0));
    bif.start = 1'b1;
    for (j = 0; j < int'(NCONT); j++) begin
      bif.bin = b[j];
      step();
      if (j % int'(PERIOD) == int'(LAT)) begin
        check_bit("cont_done", bif.done, 1'b1);
        check_bit("cont_busy_low", bif.busy, 1'b0);
        check_word("cont_bcd", bif.bcd, bcd_ref(b[j - int'(LAT)]));
        check_bit("cont_overflow", bif.overflow, 32'(b[j - int'(LAT)]) > MAX_VAL);
        last_bcd = bcd_ref(b[j - int'(LAT)]);
      end else begin
        check_bit("cont_no_done", bif.done, 1'b0);
        check_bit("cont_busy", bif.busy, 1'b1);
      end
    end
    bif.start = 1'b0;
    step();
    check_bit("cont_stop_idle", bif.busy, 1'b0);
    check_word("cont_bcd_held", bif.bcd, last_bcd);

    // reset mid-conversion abandons the work
    bif.start = 1'b1;
    bif.bin   = 27'd87654321;
    step();
    bif.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check_bit("midrst_no_done_pre", bif.done, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_word("midrst_bcd", bif.bcd, 32'h0);
    check_bit("midrst_busy", bif.busy, 1'b0);
    check_bit("midrst_done", bif.done, 1'b0);
    check_bit("midrst_overflow", bif.overflow, 1'b0);
    check_bit("midrst_display_en", bif.display_en, 1'b0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check_bit("postrst_no_done", bif.done, 1'b0);
    end
    check_word("postrst_bcd", bif.bcd, 32'h0);
    check_bit("postrst_display_en", bif.display_en, 1'b0);
    last_bcd = '0;
    convert(27'd87654321);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
